// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the RV32M divide sequencer.
// Optional build macro DIV_FASTPATH_EN is consumed by div_seq_ctrl.
package div_seq_ctrl_pkg;

  localparam int unsigned DIV_DATA_WIDTH  = 32;
  localparam int unsigned DIV_RADDR_WIDTH = 5;

  localparam logic [DIV_RADDR_WIDTH-1:0] ZERO_REG = '0;
  localparam logic [DIV_DATA_WIDTH-1:0]  ZERO     = '0;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  // Per-operation context captured at launch.
  typedef struct packed {
    div_op_e op;
    logic    sign_a;
    logic    sign_b;
    logic    div_zero;
    logic    ovf;
  } div_ctx_t;

  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_seq_ctrl_div_step.sv
// One restoring-division iteration: shift a dividend bit into the remainder,
// trial-subtract the divisor and shift the resulting quotient bit in.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] quot_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] quot_out
);

  logic [W:0] shifted;
  logic [W:0] diff;

  assign shifted  = {rem_in, quot_in[W-1]};
  assign diff     = shifted - {1'b0, divisor};
  // Borrow out of the trial subtract means restore the shifted remainder.
  assign rem_out  = diff[W] ? shifted[W-1:0] : diff[W-1:0];
  assign quot_out = {quot_in[W-2:0], ~diff[W]};

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer with pipeline stall and writeback.
// Define DIV_FASTPATH_EN to skip the iteration phase for divide-by-zero and signed overflow.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DIV_DATA_WIDTH,
  parameter int unsigned RADDR_WIDTH = DIV_RADDR_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [1:0]             op_i,
  input  logic [DATA_WIDTH-1:0]  dividend_i,
  input  logic [DATA_WIDTH-1:0]  divisor_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   stall_req_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o
);

  localparam int unsigned          CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  div_ctx_t               ctx_q, ctx_d;
  logic [DATA_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0]  quot_q, quot_d;
  logic [DATA_WIDTH-1:0]  dvsr_q, dvsr_d;
  logic [DATA_WIDTH-1:0]  dvnd_q, dvnd_d;
  logic [RADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                   busy_d, done_d;
  logic [DATA_WIDTH-1:0]  result_d;
  logic [RADDR_WIDTH-1:0] raddr_d;

  // Launch-side operand decode.
  div_op_e               op_in;
  logic                  in_signed, a_neg, b_neg, in_zero, in_ovf;
  logic [DATA_WIDTH-1:0] abs_a, abs_b;

  assign op_in     = div_op_e'(op_i);
  assign in_signed = op_is_signed(op_in);
  assign a_neg     = in_signed & dividend_i[DATA_WIDTH-1];
  assign b_neg     = in_signed & divisor_i[DATA_WIDTH-1];
  assign abs_a     = a_neg ? (~dividend_i + DATA_WIDTH'(1)) : dividend_i;
  assign abs_b     = b_neg ? (~divisor_i + DATA_WIDTH'(1)) : divisor_i;
  assign in_zero   = (divisor_i == '0);
  assign in_ovf    = in_signed & (dividend_i == MIN_NEG) & (divisor_i == '1);

  logic [DATA_WIDTH-1:0] step_rem, step_quot;

  div_step #(.W(DATA_WIDTH)) u_div_step (
    .rem_in   (rem_q),
    .quot_in  (quot_q),
    .divisor  (dvsr_q),
    .rem_out  (step_rem),
    .quot_out (step_quot)
  );

  // Sign correction and RISC-V special-case results.
  logic [DATA_WIDTH-1:0] q_fix, r_fix, fix_result;

  always_comb begin
    q_fix = (ctx_q.sign_a ^ ctx_q.sign_b) ? (~quot_q + DATA_WIDTH'(1)) : quot_q;
    r_fix = ctx_q.sign_a ? (~rem_q + DATA_WIDTH'(1)) : rem_q;
    if (ctx_q.div_zero) begin
      q_fix = '1;
      r_fix = dvnd_q;
    end else if (ctx_q.ovf) begin
      q_fix = MIN_NEG;
      r_fix = '0;
    end
    fix_result = op_is_rem(ctx_q.op) ? r_fix : q_fix;
  end

  assign stall_req_o = ((state_q == IDLE) && start_i) || (state_q == CALC) || (state_q == FIX);

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctx_d    = ctx_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    dvnd_d   = dvnd_q;
    waddr_d  = waddr_q;
    result_d = result_o;
    raddr_d  = reg_waddr_o;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          ctx_d.op       = op_in;
          ctx_d.sign_a   = a_neg;
          ctx_d.sign_b   = b_neg;
          ctx_d.div_zero = in_zero;
          ctx_d.ovf      = in_ovf;
          rem_d          = '0;
          quot_d         = abs_a;
          dvsr_d         = abs_b;
          dvnd_d         = dividend_i;
          waddr_d        = reg_waddr_i;
          cnt_d          = '0;
`ifdef DIV_FASTPATH_EN
          state_d        = (in_zero || in_ovf) ? FIX : CALC;
`else
          state_d        = CALC;
`endif
        end
      end
      CALC: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        result_d = fix_result;
        raddr_d  = waddr_q;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A flush kills the operation and suppresses any writeback this edge.
    if (abort_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      done_d   = 1'b0;
      result_d = result_o;
      raddr_d  = reg_waddr_o;
    end

    busy_d = (state_d == CALC) || (state_d == FIX);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ctx_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      dvsr_q      <= '0;
      dvnd_q      <= '0;
      waddr_q     <= RADDR_WIDTH'(ZERO_REG);
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      reg_we_o    <= 1'b0;
      result_o    <= DATA_WIDTH'(ZERO);
      reg_waddr_o <= RADDR_WIDTH'(ZERO_REG);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctx_q       <= ctx_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      dvsr_q      <= dvsr_d;
      dvnd_q      <= dvnd_d;
      waddr_q     <= waddr_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      reg_we_o    <= done_d;
      result_o    <= result_d;
      reg_waddr_o <= raddr_d;
    end
  end

endmodule
